// File: rtl/sobel_window_gen_pkg.sv
// Shared pixel/window types for the Sobel front end, plus default image geometry.
// sobel_core and sobel_window_gen both see the same sobel_matrix layout.
package sobel_window_gen_pkg;

    localparam int PIXEL_WIDTH_IN = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    typedef logic [PIXEL_WIDTH_IN-1:0] pixel_t;

    // pix0 is the oldest (leftmost) column, pix2 the newest (rightmost)
    typedef struct packed {
        pixel_t pix0;
        pixel_t pix1;
        pixel_t pix2;
    } sobel_vector;

    // vector0 is the oldest (top) row, vector2 the current (bottom) row
    typedef struct packed {
        sobel_vector vector0;
        sobel_vector vector1;
        sobel_vector vector2;
    } sobel_matrix;

    function automatic sobel_vector shift_vector(input sobel_vector v, input pixel_t tap);
        sobel_vector r;
        r.pix0 = v.pix1;
        r.pix1 = v.pix2;
        r.pix2 = tap;
        return r;
    endfunction

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// One-line delay: circular RAM, read-before-write, dout_o is the pixel written DEPTH enables ago.
// rst_i restarts the pointer; an enable in the same cycle writes the first slot.
module sobel_line_buffer
    import sobel_window_gen_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int WIDTH = PIXEL_WIDTH_IN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] addr;

    assign addr   = rst_i ? '0 : ptr;
    assign dout_o = mem[addr];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem[addr] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            ptr <= (addr == PTR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
        end else if (rst_i) begin
            ptr <= '0;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding sobel_core: two cascaded line buffers,
// a shifting 3x3 register window, raster counters and valid/eof generation.
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  pixel_t      pixel_i,
    input  logic        pixel_valid_i,
    input  logic        sof_i,
    output logic        pixel_ready_o,
    output sobel_matrix matrix_pixels_o,
    output logic        matrix_valid_o,
    input  logic        matrix_ready_i,
    output logic        eof_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col, cur_col, next_col;
    logic [ROW_W-1:0] row, cur_row, next_row;
    logic             accept;
    logic             last_col, last_row;
    logic             line_en, line_restart;
    pixel_t           lb1_out, lb2_out;
    sobel_matrix      window;
    logic             valid, eof;

    assign pixel_ready_o   = !valid || matrix_ready_i;
    assign accept          = pixel_valid_i && pixel_ready_o;
    assign matrix_pixels_o = window;
    assign matrix_valid_o  = valid;
    assign eof_o           = eof;

    // An accepted sof_i relocates the incoming pixel to (0,0) whatever the counters say
    always_comb begin
        cur_col  = sof_i ? '0 : col;
        cur_row  = sof_i ? '0 : row;
        last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
        last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
        next_col = last_col ? '0 : cur_col + 1'b1;
        next_row = cur_row;
        if (last_col) begin
            next_row = last_row ? '0 : cur_row + 1'b1;
        end
    end

    assign line_en      = accept && !rst_i;
    assign line_restart = rst_i || (accept && sof_i);

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIXEL_WIDTH_IN)
    ) lb1 (
        .clk_i  (clk_i),
        .rst_i  (line_restart),
        .en_i   (line_en),
        .din_i  (pixel_i),
        .dout_o (lb1_out)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIXEL_WIDTH_IN)
    ) lb2 (
        .clk_i  (clk_i),
        .rst_i  (line_restart),
        .en_i   (line_en),
        .din_i  (lb1_out),
        .dout_o (lb2_out)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col    <= '0;
            row    <= '0;
            window <= '0;
            valid  <= 1'b0;
            eof    <= 1'b0;
        end else if (accept) begin
            col            <= next_col;
            row            <= next_row;
            window.vector0 <= shift_vector(window.vector0, lb2_out);
            window.vector1 <= shift_vector(window.vector1, lb1_out);
            window.vector2 <= shift_vector(window.vector2, pixel_i);
            // Rows/columns 0 and 1 hold stale or previous-line data, never flagged valid
            valid          <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            eof            <= last_row && last_col;
        end else if (matrix_ready_i) begin
            valid <= 1'b0;
            eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 4x4 instance (stall, abort, back-to-back, reset)
// and a 5x3 instance (input gaps); expected windows are built from the pixel formula.
module tb_sobel_window_gen;
    import sobel_window_gen_pkg::*;

    typedef struct packed {
        sobel_matrix mat;
        logic        eof;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        a_pix_valid = 1'b0, a_sof = 1'b0, a_pix_ready, a_mready = 1'b1, a_mvalid, a_eof;
    pixel_t      a_pix = '0;
    sobel_matrix a_mat;
    logic        b_pix_valid = 1'b0, b_sof = 1'b0, b_pix_ready, b_mvalid, b_eof;
    logic        b_mready = 1'b1;
    pixel_t      b_pix = '0;
    sobel_matrix b_mat;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;
    int   stall_left = 0;
    bit   stall_arm = 1'b0;
    bit   hold_low = 1'b0;

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .pixel_i(a_pix), .pixel_valid_i(a_pix_valid), .sof_i(a_sof),
        .pixel_ready_o(a_pix_ready), .matrix_pixels_o(a_mat), .matrix_valid_o(a_mvalid),
        .matrix_ready_i(a_mready), .eof_o(a_eof)
    );

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .pixel_i(b_pix), .pixel_valid_i(b_pix_valid), .sof_i(b_sof),
        .pixel_ready_o(b_pix_ready), .matrix_pixels_o(b_mat), .matrix_valid_o(b_mvalid),
        .matrix_ready_i(b_mready), .eof_o(b_eof)
    );

    function automatic pixel_t pv(input int base, input int r, input int c);
        return pixel_t'(base + r * 16 + c);
    endfunction

    // Window produced by accepting (r,c): rows r-2..r, columns c-2..c
    function automatic exp_t model(input int base, input int r, input int c, input bit eof);
        exp_t e;
        e.mat.vector0 = '{pix0: pv(base, r-2, c-2), pix1: pv(base, r-2, c-1), pix2: pv(base, r-2, c)};
        e.mat.vector1 = '{pix0: pv(base, r-1, c-2), pix1: pv(base, r-1, c-1), pix2: pv(base, r-1, c)};
        e.mat.vector2 = '{pix0: pv(base, r,   c-2), pix1: pv(base, r,   c-1), pix2: pv(base, r,   c)};
        e.eof = eof;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_a(input int base, input int r, input int c, input bit sof);
        int n = 0;
        @(negedge clk);
        a_pix = pv(base, r, c);
        a_sof = sof;
        a_pix_valid = 1'b1;
        #1;
        while (!a_pix_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!a_pix_ready) begin
            checks++;
            failures++;
            $display("FAIL a_accept_timeout actual=0 required=1");
        end else if (r >= 2 && c >= 2) begin
            qa.push_back(model(base, r, c, (r == 3 && c == 3)));
        end
        @(posedge clk);
        #1;
        a_pix_valid = 1'b0;
        a_sof = 1'b0;
    endtask

    task automatic send_frame_a(input int base, input bit sof_first, input int count);
        for (int i = 0; i < count; i++) begin
            send_a(base, i / 4, i % 4, sof_first && (i == 0));
        end
    endtask

    task automatic send_b(input int base, input int r, input int c, input bit sof, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        b_pix = pv(base, r, c);
        b_sof = sof;
        b_pix_valid = 1'b1;
        #1;
        while (!b_pix_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!b_pix_ready) begin
            checks++;
            failures++;
            $display("FAIL b_accept_timeout actual=0 required=1");
        end else if (r >= 2 && c >= 2) begin
            qb.push_back(model(base, r, c, (r == 2 && c == 4)));
        end
        @(posedge clk);
        #1;
        b_pix_valid = 1'b0;
        b_sof = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, 128'(qa.size() + qb.size()), 128'(0));
    endtask

    // Downstream ready for instance A: optional 3-cycle stall on the next window, or forced low
    always @(posedge clk) begin
        #1;
        if (stall_arm && a_mvalid) begin
            stall_arm = 1'b0;
            stall_left = 3;
        end
        if (hold_low) begin
            a_mready = 1'b0;
        end else if (stall_left > 0) begin
            a_mready = 1'b0;
            stall_left--;
        end else begin
            a_mready = 1'b1;
        end
    end

    exp_t held;
    bit   held_ok = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_mvalid && !a_mready) begin
                check("a_stall_pixel_ready", 128'(a_pix_ready), 128'(0));
                if (held_ok) check("a_stall_hold", 128'({a_mat, a_eof}), 128'(held));
                held = {a_mat, a_eof};
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (a_mvalid && a_mready) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_window actual=%0h required=none", a_mat);
                end else begin
                    e = qa.pop_front();
                    check("a_window", 128'(a_mat), 128'(e.mat));
                    check("a_eof", 128'(a_eof), 128'(e.eof));
                end
            end
            if (b_mvalid && b_mready) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_window actual=%0h required=none", b_mat);
                end else begin
                    e = qb.pop_front();
                    check("b_window", 128'(b_mat), 128'(e.mat));
                    check("b_eof", 128'(b_eof), 128'(e.eof));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        exp_t first;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 128'(a_mvalid), 128'(0));
        check("reset_eof", 128'(a_eof), 128'(0));
        check("reset_matrix", 128'(a_mat), 128'(0));
        check("reset_pixel_ready", 128'(a_pix_ready), 128'(1));

        // Hand value of the first 4x4 window, checked against the formula
        first = model(0, 2, 2, 1'b0);
        check("first_window_formula", 128'(first.mat),
              128'({8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34}));

        // Plain 4x4 frame
        send_frame_a(0, 1'b1, 16);
        wait_drain("basic_drain");

        // Same frame with a 3-cycle downstream stall on the first window
        stall_arm = 1'b1;
        send_frame_a(0, 1'b1, 16);
        wait_drain("stall_drain");

        // 5x3 frame without gaps, then with random input gaps
        for (int i = 0; i < 15; i++) send_b(0, i / 5, i % 5, i == 0, 0);
        wait_drain("b_nogap_drain");
        for (int i = 0; i < 15; i++) send_b(0, i / 5, i % 5, i == 0, int'($urandom_range(0, 1)));
        wait_drain("b_gap_drain");

        // Frame aborted by sof at (2,1), then a full frame
        send_frame_a(8'h40, 1'b1, 9);
        send_frame_a(8'h80, 1'b1, 16);
        wait_drain("abort_drain");

        // Two back-to-back frames, sof only on the first
        send_frame_a(8'h00, 1'b1, 16);
        send_frame_a(8'h90, 1'b0, 16);
        wait_drain("b2b_drain");

        // Reset while a window is held by a stalled downstream
        hold_low = 1'b1;
        send_frame_a(8'h20, 1'b1, 11);
        repeat (2) @(negedge clk);
        check("pre_reset_valid", 128'(a_mvalid), 128'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_reset_valid", 128'(a_mvalid), 128'(0));
        check("mid_reset_eof", 128'(a_eof), 128'(0));
        check("mid_reset_pixel_ready", 128'(a_pix_ready), 128'(1));
        qa.delete();
        hold_low = 1'b0;
        send_frame_a(8'h50, 1'b1, 16);
        wait_drain("post_reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
